ld2_write_seq: RTL

LD2_WRITE_SEQ -- requirements
Module: ld2_write_seq

---
 rtl/ld2_write_seq.sv | 136 +++++++++++++
 1 files changed

// File: rtl/ld2_write_seq.sv
// Write sequencer for a bank of level-sensitive latches: sets up the shared D bus,
// pulses one active-low gate, holds, then reads the word back and flags mismatches.
module ld2_write_seq #(
    parameter int WIDTH = 8,
    parameter int NLAT  = 4,
    parameter int TSU   = 1,
    parameter int TPW   = 2,
    parameter int THD   = 1
) (
    input  logic                      CP,
    input  logic                      CD,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [$clog2(NLAT)-1:0]   req_addr,
    input  logic [WIDTH-1:0]          req_data,
    output logic [WIDTH-1:0]          ld_d,
    output logic [NLAT-1:0]           ld_gn,
    input  logic [NLAT*WIDTH-1:0]     ld_q,
    output logic                      done,
    output logic                      err,
    output logic [7:0]                err_cnt,
    input  logic                      err_clr
);
    localparam int AW    = $clog2(NLAT);
    localparam int CW    = 16;
    localparam int TSU_E = (TSU < 1) ? 1 : TSU;
    localparam int TPW_E = (TPW < 1) ? 1 : TPW;
    localparam int THD_E = (THD < 1) ? 1 : THD;
    localparam logic [CW-1:0] SU_LAST = CW'(TSU_E - 1);
    localparam logic [CW-1:0] PW_LAST = CW'(TPW_E - 1);
    localparam logic [CW-1:0] HD_LAST = CW'(THD_E - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        OPEN  = 3'd2,
        HOLD  = 3'd3,
        CHECK = 3'd4
    } state_t;

    // Handshake: a request transfers on a CP edge where req_valid and req_ready are both 1.
    state_t                       state, state_nxt;
    logic [CW-1:0]                cnt, cnt_nxt;
    logic [AW-1:0]                addr;
    logic                         accept;
    logic                         ready_nxt, done_nxt, err_nxt;
    logic [NLAT-1:0]              gn_nxt;
    logic [7:0]                   err_cnt_nxt;
    logic [NLAT-1:0][WIDTH-1:0]   q_words;

    assign accept  = req_valid & req_ready;
    assign q_words = ld_q;

    always_ff @(posedge CP or negedge CD) begin
        if (!CD) begin
            state     <= IDLE;
            cnt       <= '0;
            addr      <= '0;
            ld_d      <= '0;
            ld_gn     <= '1;
            req_ready <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            err_cnt   <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            if (accept) begin
                addr <= req_addr;
                ld_d <= req_data;
            end
            ld_gn     <= gn_nxt;
            req_ready <= ready_nxt;
            done      <= done_nxt;
            err       <= err_nxt;
            err_cnt   <= err_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = SETUP;
                    cnt_nxt   = '0;
                end
            end
            SETUP: begin
                if (cnt == SU_LAST) begin
                    state_nxt = OPEN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            OPEN: begin
                if (cnt == PW_LAST) begin
                    state_nxt = HOLD;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            HOLD: begin
                if (cnt == HD_LAST) begin
                    state_nxt = CHECK;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            CHECK:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so every one of them comes straight off a flop.
    always_comb begin
        ready_nxt = (state_nxt == IDLE);
        gn_nxt    = '1;
        if (state_nxt == OPEN) begin
            gn_nxt[addr] = 1'b0;
        end
        done_nxt = (state_nxt == CHECK);
        err_nxt  = (state_nxt == CHECK) && (q_words[addr] != ld_d);
        if (err_clr) begin
            err_cnt_nxt = '0;
        end else if (done && err && (err_cnt != 8'hFF)) begin
            err_cnt_nxt = err_cnt + 8'd1;
        end else begin
            err_cnt_nxt = err_cnt;
        end
    end
endmodule
